// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad sequencer: key codes, ALU
// operation encodings, FSM state enum, default operand width and the signed
// BCD operand struct.
package calc_pkg;

  localparam int DEFAULT_DIGITS = 8;

  // Key codes delivered by the keypad scanner.
  localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
  localparam logic [4:0] KEY_DOT       = 5'd10;
  localparam logic [4:0] KEY_SIGN      = 5'd11;
  localparam logic [4:0] KEY_ADD       = 5'd12;
  localparam logic [4:0] KEY_SUB       = 5'd13;
  localparam logic [4:0] KEY_MUL       = 5'd14;
  localparam logic [4:0] KEY_DIV       = 5'd15;
  localparam logic [4:0] KEY_POW       = 5'd16;
  localparam logic [4:0] KEY_EQUALS    = 5'd17;
  localparam logic [4:0] KEY_CLEAR     = 5'd18;

  // ALU operation encodings; operator keys map onto these in order.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_POW = 3'd4;

  typedef enum logic [2:0] {
    ST_ENTRY_A  = 3'd0,
    ST_OP_WAIT  = 3'd1,
    ST_ENTRY_B  = 3'd2,
    ST_EXEC     = 3'd3,
    ST_WAIT_ALU = 3'd4,
    ST_RESULT   = 3'd5,
    ST_ERROR    = 3'd6
  } state_e;

  // Signed BCD value: sign, 8 packed BCD digits, digits after the point.
  typedef struct packed {
    logic        sgn;
    logic [31:0] num;
    logic [2:0]  dp;
  } bcd_t;

  // Map an operator key (12..16) onto its ALU op code.
  function automatic logic [2:0] key_to_op(input logic [4:0] code);
    logic [4:0] diff;
    diff = code - KEY_ADD;
    return diff[2:0];
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Keypad, ALU and display signal bundle for calc_sequencer.
// Key handshake: a key is consumed at a rising clock edge where key_valid and
// key_ready are both high; the source holds key_code stable while key_valid is
// high and key_ready is low. alu_start is a single-cycle pulse; alu_done is a
// single-cycle pulse that qualifies alu_error and the result fields.
interface calc_sequencer_if;
  import calc_pkg::*;

  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_ready;

  logic        alu_start;
  logic [2:0]  alu_op;
  logic        alu_sgn0;
  logic [31:0] alu_num0;
  logic [2:0]  alu_dp0;
  logic        alu_sgn1;
  logic [31:0] alu_num1;
  logic [2:0]  alu_dp1;
  logic        alu_done;
  logic        alu_error;
  logic [31:0] alu_result;
  logic        alu_res_sgn;
  logic [2:0]  alu_res_dp;

  logic [31:0] disp_num;
  logic        disp_sgn;
  logic [2:0]  disp_dp;
  logic        disp_error;
  logic        busy;

  state_e      dbg_state;

  modport slave (
    input  key_valid, key_code, alu_done, alu_error, alu_result,
           alu_res_sgn, alu_res_dp,
    output key_ready, alu_start, alu_op, alu_sgn0, alu_num0, alu_dp0,
           alu_sgn1, alu_num1, alu_dp1, disp_num, disp_sgn, disp_dp,
           disp_error, busy, dbg_state
  );

  modport master (
    output key_valid, key_code, alu_done, alu_error, alu_result,
           alu_res_sgn, alu_res_dp,
    input  key_ready, alu_start, alu_op, alu_sgn0, alu_num0, alu_dp0,
           alu_sgn1, alu_num1, alu_dp1, disp_num, disp_sgn, disp_dp,
           disp_error, busy, dbg_state
  );

endinterface

// File: rtl/bcd_entry_reg.sv
// Operand entry register: shifts BCD digits in from the right, counts digits
// after the decimal point, toggles sign. i_fresh restarts the entry from zero
// in the same cycle a key is applied, so a new operand can begin with that key.
module bcd_entry_reg
  import calc_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_clear,
  input  logic       i_fresh,
  input  logic       i_digit_en,
  input  logic [3:0] i_digit,
  input  logic       i_dot_en,
  input  logic       i_sign_en,
  output bcd_t       o_val
);

  logic [31:0] r_num;
  logic        r_sgn;
  logic [2:0]  r_dp;
  logic        r_dot;
  logic [3:0]  r_cnt;

  logic [31:0] w_num_b, w_num_n;
  logic        w_sgn_b, w_sgn_n;
  logic [2:0]  w_dp_b, w_dp_n;
  logic        w_dot_b, w_dot_n;
  logic [3:0]  w_cnt_b, w_cnt_n;
  logic        w_digit_ok;

  // Next entry value: optional restart, then apply the key for this cycle.
  always_comb begin
    w_num_b = i_fresh ? 32'd0 : r_num;
    w_sgn_b = i_fresh ? 1'b0  : r_sgn;
    w_dp_b  = i_fresh ? 3'd0  : r_dp;
    w_dot_b = i_fresh ? 1'b0  : r_dot;
    w_cnt_b = i_fresh ? 4'd0  : r_cnt;
    w_num_n = w_num_b;
    w_sgn_n = w_sgn_b;
    w_dp_n  = w_dp_b;
    w_dot_n = w_dot_b;
    w_cnt_n = w_cnt_b;
    // A digit is dropped when the register is full or dp would overflow 7.
    w_digit_ok = (w_cnt_b < 4'(DIGITS)) && !(w_dot_b && (w_dp_b == 3'd7));
    if (i_digit_en && w_digit_ok) begin
      w_num_n = {w_num_b[27:0], i_digit};
      w_cnt_n = w_cnt_b + 4'd1;
      if (w_dot_b) w_dp_n = w_dp_b + 3'd1;
    end
    if (i_dot_en) w_dot_n = 1'b1;
    if (i_sign_en) w_sgn_n = ~w_sgn_b;
  end

  // Entry state register; clear wins over any key in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_num <= 32'd0;
      r_sgn <= 1'b0;
      r_dp  <= 3'd0;
      r_dot <= 1'b0;
      r_cnt <= 4'd0;
    end else if (i_clear) begin
      r_num <= 32'd0;
      r_sgn <= 1'b0;
      r_dp  <= 3'd0;
      r_dot <= 1'b0;
      r_cnt <= 4'd0;
    end else begin
      r_num <= w_num_n;
      r_sgn <= w_sgn_n;
      r_dp  <= w_dp_n;
      r_dot <= w_dot_n;
      r_cnt <= w_cnt_n;
    end
  end

  assign o_val = '{sgn: r_sgn, num: r_num, dp: r_dp};

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer for the BCD arithmetic unit. Builds operands A and B
// from key presses, starts the ALU, waits for completion, drives the display
// and supports chaining (result becomes the next A).
// Optional macro CALC_TIMEOUT_EN adds a watchdog on the ALU wait.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DIGITS         = DEFAULT_DIGITS,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  calc_sequencer_if.slave   bus
);

  if (DIGITS < 1 || DIGITS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("calc_sequencer: DIGITS must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  state_e     r_state, w_state_n;
  bcd_t       r_a, w_a_n;
  bcd_t       r_b, w_b_n;
  bcd_t       r_res, w_res_n;
  bcd_t       r_disp, w_disp;
  logic [2:0] r_op, w_op_n;
  logic [2:0] r_pend_op, w_pend_op_n;
  logic       r_chain, w_chain_n;

  bcd_t       w_entry;
  logic       w_ent_clear, w_ent_fresh, w_ent_digit, w_ent_dot, w_ent_sign;
  logic       w_key_acc, w_is_digit, w_is_dot, w_is_sign, w_is_op;
  logic       w_is_eq, w_is_clr, w_key_ready, w_alu_start, w_timeout;
  logic [2:0] w_key_op;

  bcd_entry_reg #(.DIGITS(DIGITS)) u_entry (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_clear    (w_ent_clear),
    .i_fresh    (w_ent_fresh),
    .i_digit_en (w_ent_digit),
    .i_digit    (bus.key_code[3:0]),
    .i_dot_en   (w_ent_dot),
    .i_sign_en  (w_ent_sign),
    .o_val      (w_entry)
  );

`ifdef CALC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Watchdog: counts cycles spent waiting for the ALU, zero elsewhere.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_tmo_cnt <= '0;
    else if (r_state == ST_WAIT_ALU) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    else r_tmo_cnt <= '0;
  end

  assign w_timeout = (r_state == ST_WAIT_ALU) &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_key_ready = (r_state != ST_EXEC) && (r_state != ST_WAIT_ALU);
  assign w_key_acc   = bus.key_valid && w_key_ready;
  assign w_is_digit  = bus.key_code <= KEY_DIGIT_MAX;
  assign w_is_dot    = bus.key_code == KEY_DOT;
  assign w_is_sign   = bus.key_code == KEY_SIGN;
  assign w_is_op     = (bus.key_code >= KEY_ADD) && (bus.key_code <= KEY_POW);
  assign w_is_eq     = bus.key_code == KEY_EQUALS;
  assign w_is_clr    = bus.key_code == KEY_CLEAR;
  assign w_key_op    = key_to_op(bus.key_code);

  // Next-state, operand latching, entry control and ALU start.
  always_comb begin
    w_state_n   = r_state;
    w_a_n       = r_a;
    w_b_n       = r_b;
    w_res_n     = r_res;
    w_op_n      = r_op;
    w_pend_op_n = r_pend_op;
    w_chain_n   = r_chain;
    w_ent_clear = 1'b0;
    w_ent_fresh = 1'b0;
    w_ent_digit = 1'b0;
    w_ent_dot   = 1'b0;
    w_ent_sign  = 1'b0;
    w_alu_start = 1'b0;
    if (w_key_acc && w_is_clr) begin
      w_state_n   = ST_ENTRY_A;
      w_a_n       = '0;
      w_b_n       = '0;
      w_res_n     = '0;
      w_op_n      = 3'd0;
      w_pend_op_n = 3'd0;
      w_chain_n   = 1'b0;
      w_ent_clear = 1'b1;
    end else begin
      case (r_state)
        ST_ENTRY_A: if (w_key_acc) begin
          w_ent_digit = w_is_digit;
          w_ent_dot   = w_is_dot;
          w_ent_sign  = w_is_sign;
          if (w_is_op) begin
            w_op_n    = w_key_op;
            w_a_n     = w_entry;
            w_state_n = ST_OP_WAIT;
          end
        end
        ST_OP_WAIT: if (w_key_acc) begin
          if (w_is_digit || w_is_dot) begin
            w_ent_fresh = 1'b1;
            w_ent_digit = w_is_digit;
            w_ent_dot   = w_is_dot;
            w_state_n   = ST_ENTRY_B;
          end else if (w_is_op) begin
            w_op_n = w_key_op;
          end
        end
        ST_ENTRY_B: if (w_key_acc) begin
          w_ent_digit = w_is_digit;
          w_ent_dot   = w_is_dot;
          w_ent_sign  = w_is_sign;
          if (w_is_eq || w_is_op) begin
            w_b_n     = w_entry;
            w_chain_n = w_is_op;
            if (w_is_op) w_pend_op_n = w_key_op;
            w_state_n = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if ((r_op == OP_DIV) && (r_b.num == 32'd0)) begin
            w_state_n = ST_ERROR;
          end else begin
            w_alu_start = 1'b1;
            w_state_n   = ST_WAIT_ALU;
          end
        end
        ST_WAIT_ALU: begin
          if (bus.alu_done) begin
            w_res_n = '{sgn: bus.alu_res_sgn, num: bus.alu_result,
                        dp: bus.alu_res_dp};
            if (bus.alu_error) begin
              w_state_n = ST_ERROR;
            end else if (r_chain) begin
              w_a_n     = '{sgn: bus.alu_res_sgn, num: bus.alu_result,
                            dp: bus.alu_res_dp};
              w_op_n    = r_pend_op;
              w_chain_n = 1'b0;
              w_state_n = ST_OP_WAIT;
            end else begin
              w_state_n = ST_RESULT;
            end
          end else if (w_timeout) begin
            w_state_n = ST_ERROR;
          end
        end
        ST_RESULT: if (w_key_acc) begin
          if (w_is_digit || w_is_dot) begin
            w_ent_fresh = 1'b1;
            w_ent_digit = w_is_digit;
            w_ent_dot   = w_is_dot;
            w_state_n   = ST_ENTRY_A;
          end else if (w_is_op) begin
            w_a_n     = r_res;
            w_op_n    = w_key_op;
            w_state_n = ST_OP_WAIT;
          end else if (w_is_sign) begin
            w_res_n.sgn = ~r_res.sgn;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_ENTRY_A;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_op      <= 3'd0;
      r_pend_op <= 3'd0;
      r_chain   <= 1'b0;
      r_disp    <= '0;
    end else begin
      r_state   <= w_state_n;
      r_a       <= w_a_n;
      r_b       <= w_b_n;
      r_res     <= w_res_n;
      r_op      <= w_op_n;
      r_pend_op <= w_pend_op_n;
      r_chain   <= w_chain_n;
      r_disp    <= w_disp;
    end
  end

  // Display source per state; EXEC/WAIT_ALU hold the last shown value.
  always_comb begin
    w_disp = r_disp;
    case (r_state)
      ST_ENTRY_A, ST_ENTRY_B: w_disp = w_entry;
      ST_OP_WAIT:             w_disp = r_a;
      ST_RESULT:              w_disp = r_res;
      ST_ERROR:               w_disp = '0;
      default:                w_disp = r_disp;
    endcase
  end

  assign bus.key_ready  = w_key_ready;
  assign bus.alu_start  = w_alu_start;
  assign bus.alu_op     = r_op;
  assign bus.alu_sgn0   = r_a.sgn;
  assign bus.alu_num0   = r_a.num;
  assign bus.alu_dp0    = r_a.dp;
  assign bus.alu_sgn1   = r_b.sgn;
  assign bus.alu_num1   = r_b.num;
  assign bus.alu_dp1    = r_b.dp;
  assign bus.disp_num   = w_disp.num;
  assign bus.disp_sgn   = w_disp.sgn;
  assign bus.disp_dp    = w_disp.dp;
  assign bus.disp_error = (r_state == ST_ERROR);
  assign bus.busy       = (r_state == ST_EXEC) || (r_state == ST_WAIT_ALU);
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed testbench for calc_sequencer: keypad driver, ALU responder,
// start-pulse monitor and per-scenario checks.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  logic [2:0]  cap_op;
  logic [31:0] cap_num0, cap_num1;

  calc_sequencer_if u_if ();

  calc_sequencer u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Start-pulse monitor
  always @(negedge clock) if (u_if.alu_start === 1'b1) start_cnt++;

  // Driver tasks
  task automatic send_key(input logic [4:0] k);
    @(negedge clock);
    u_if.key_valid = 1'b1;
    u_if.key_code  = k;
    @(negedge clock);
    u_if.key_valid = 1'b0;
    u_if.key_code  = 5'd0;
  endtask

  task automatic alu_respond(input logic [31:0] res, input logic err, input int dly);
    int waited;
    waited = 0;
    while (u_if.alu_start !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (u_if.alu_start !== 1'b1) begin
      errors++;
      $display("FAIL alu_start_wait: alu_start=%b required 1 within 20 cycles", u_if.alu_start);
    end
    cap_op   = u_if.alu_op;
    cap_num0 = u_if.alu_num0;
    cap_num1 = u_if.alu_num1;
    repeat (dly) @(negedge clock);
    u_if.alu_result  = res;
    u_if.alu_error   = err;
    u_if.alu_res_sgn = 1'b0;
    u_if.alu_res_dp  = 3'd0;
    u_if.alu_done    = 1'b1;
    @(negedge clock);
    u_if.alu_done    = 1'b0;
    u_if.alu_error   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++; if (u_if.dbg_state !== ST_ENTRY_A) begin errors++; $display("FAIL reset_state: got %0d required %0d", u_if.dbg_state, ST_ENTRY_A); end
    checks++; if (u_if.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b required 1", u_if.key_ready); end
    checks++; if (u_if.busy !== 1'b0 || u_if.alu_start !== 1'b0) begin errors++; $display("FAIL reset_busy_start: busy=%b start=%b required 0 0", u_if.busy, u_if.alu_start); end
    checks++; if (u_if.disp_num !== 32'd0 || u_if.disp_error !== 1'b0) begin errors++; $display("FAIL reset_disp: num=%h err=%b required 0 0", u_if.disp_num, u_if.disp_error); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (u_if.alu_num0 !== 32'd0 || u_if.alu_num1 !== 32'd0 || u_if.alu_op !== 3'd0) begin errors++; $display("FAIL reset_operands: num0=%h num1=%h op=%0d required 0", u_if.alu_num0, u_if.alu_num1, u_if.alu_op); end
  endtask

  task automatic test_add();
    int s0;
    s0 = start_cnt;
    send_key(5'd1); send_key(5'd2);
    checks++; if (u_if.disp_num !== 32'h12) begin errors++; $display("FAIL add_entry_a: disp=%h required 00000012", u_if.disp_num); end
    send_key(KEY_ADD);
    checks++; if (u_if.dbg_state !== ST_OP_WAIT || u_if.disp_num !== 32'h12) begin errors++; $display("FAIL add_op_wait: state=%0d disp=%h required %0d 00000012", u_if.dbg_state, u_if.disp_num, ST_OP_WAIT); end
    send_key(5'd3); send_key(5'd4);
    checks++; if (u_if.disp_num !== 32'h34) begin errors++; $display("FAIL add_entry_b: disp=%h required 00000034", u_if.disp_num); end
    send_key(KEY_EQUALS);
    checks++; if (u_if.alu_start !== 1'b1 || u_if.busy !== 1'b1 || u_if.key_ready !== 1'b0) begin errors++; $display("FAIL add_start_latency: start=%b busy=%b ready=%b required 1 1 0", u_if.alu_start, u_if.busy, u_if.key_ready); end
    checks++; if (u_if.disp_num !== 32'h34) begin errors++; $display("FAIL add_exec_disp_hold: disp=%h required 00000034", u_if.disp_num); end
    alu_respond(32'h46, 1'b0, 3);
    checks++; if (cap_num0 !== 32'h12 || cap_num1 !== 32'h34 || cap_op !== OP_ADD) begin errors++; $display("FAIL add_operands: num0=%h num1=%h op=%0d required 12 34 0", cap_num0, cap_num1, cap_op); end
    checks++; if (u_if.dbg_state !== ST_RESULT || u_if.disp_num !== 32'h46) begin errors++; $display("FAIL add_result: state=%0d disp=%h required %0d 00000046", u_if.dbg_state, u_if.disp_num, ST_RESULT); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL add_start_count: got %0d required 1", start_cnt - s0); end
    send_key(KEY_SIGN);
    checks++; if (u_if.disp_sgn !== 1'b1 || u_if.disp_num !== 32'h46) begin errors++; $display("FAIL result_sign: sgn=%b disp=%h required 1 00000046", u_if.disp_sgn, u_if.disp_num); end
    send_key(KEY_CLEAR);
  endtask

  task automatic test_digit_limit();
    for (int d = 1; d <= 9; d++) send_key(5'(d));
    checks++; if (u_if.disp_num !== 32'h12345678) begin errors++; $display("FAIL digit_limit: disp=%h required 12345678", u_if.disp_num); end
    send_key(KEY_CLEAR);
    send_key(KEY_DOT);
    for (int d = 1; d <= 8; d++) send_key(5'(d));
    checks++; if (u_if.disp_num !== 32'h01234567 || u_if.disp_dp !== 3'd7) begin errors++; $display("FAIL dp_limit: disp=%h dp=%0d required 01234567 7", u_if.disp_num, u_if.disp_dp); end
    send_key(KEY_CLEAR);
  endtask

  task automatic test_dot_sign();
    send_key(5'd1); send_key(KEY_DOT); send_key(KEY_DOT); send_key(5'd5); send_key(KEY_SIGN);
    checks++; if (u_if.disp_num !== 32'h15 || u_if.disp_dp !== 3'd1 || u_if.disp_sgn !== 1'b1) begin errors++; $display("FAIL dot_sign: disp=%h dp=%0d sgn=%b required 00000015 1 1", u_if.disp_num, u_if.disp_dp, u_if.disp_sgn); end
    send_key(KEY_CLEAR);
  endtask

  task automatic test_div_zero();
    int s0;
    s0 = start_cnt;
    send_key(5'd5); send_key(KEY_DIV); send_key(5'd0); send_key(KEY_EQUALS);
    checks++; if (u_if.dbg_state !== ST_EXEC || u_if.alu_start !== 1'b0) begin errors++; $display("FAIL div0_exec: state=%0d start=%b required %0d 0", u_if.dbg_state, u_if.alu_start, ST_EXEC); end
    repeat (3) @(negedge clock);
    checks++; if (u_if.disp_error !== 1'b1 || u_if.disp_num !== 32'd0 || u_if.dbg_state !== ST_ERROR) begin errors++; $display("FAIL div0_error: err=%b disp=%h state=%0d required 1 0 %0d", u_if.disp_error, u_if.disp_num, u_if.dbg_state, ST_ERROR); end
    checks++; if (start_cnt !== s0) begin errors++; $display("FAIL div0_no_start: starts=%0d required 0", start_cnt - s0); end
    send_key(5'd7);
    checks++; if (u_if.dbg_state !== ST_ERROR || u_if.disp_num !== 32'd0) begin errors++; $display("FAIL error_ignores_keys: state=%0d disp=%h required %0d 0", u_if.dbg_state, u_if.disp_num, ST_ERROR); end
    send_key(KEY_CLEAR);
    checks++; if (u_if.disp_num !== 32'd0 || u_if.disp_error !== 1'b0 || u_if.key_ready !== 1'b1 || u_if.dbg_state !== ST_ENTRY_A) begin errors++; $display("FAIL div0_clear: disp=%h err=%b ready=%b state=%0d required 0 0 1 0", u_if.disp_num, u_if.disp_error, u_if.key_ready, u_if.dbg_state); end
  endtask

  task automatic test_chain();
    send_key(5'd2); send_key(KEY_MUL); send_key(5'd3); send_key(KEY_ADD);
    alu_respond(32'h6, 1'b0, 2);
    checks++; if (cap_num0 !== 32'h2 || cap_num1 !== 32'h3 || cap_op !== OP_MUL) begin errors++; $display("FAIL chain_first: num0=%h num1=%h op=%0d required 2 3 2", cap_num0, cap_num1, cap_op); end
    checks++; if (u_if.dbg_state !== ST_OP_WAIT || u_if.disp_num !== 32'h6) begin errors++; $display("FAIL chain_op_wait: state=%0d disp=%h required %0d 00000006", u_if.dbg_state, u_if.disp_num, ST_OP_WAIT); end
    send_key(5'd4); send_key(KEY_EQUALS);
    alu_respond(32'h10, 1'b0, 1);
    checks++; if (cap_num0 !== 32'h6 || cap_num1 !== 32'h4 || cap_op !== OP_ADD) begin errors++; $display("FAIL chain_second: num0=%h num1=%h op=%0d required 6 4 0", cap_num0, cap_num1, cap_op); end
    checks++; if (u_if.dbg_state !== ST_RESULT || u_if.disp_num !== 32'h10) begin errors++; $display("FAIL chain_result: state=%0d disp=%h required %0d 00000010", u_if.dbg_state, u_if.disp_num, ST_RESULT); end
    send_key(KEY_CLEAR);
  endtask

  task automatic test_alu_error();
    send_key(5'd9); send_key(KEY_POW); send_key(5'd9); send_key(KEY_EQUALS);
    alu_respond(32'h0, 1'b1, 2);
    checks++; if (u_if.dbg_state !== ST_ERROR || u_if.disp_error !== 1'b1) begin errors++; $display("FAIL alu_error: state=%0d err=%b required %0d 1", u_if.dbg_state, u_if.disp_error, ST_ERROR); end
    send_key(KEY_CLEAR);
  endtask

  task automatic test_async_reset();
    send_key(5'd7); send_key(KEY_ADD); send_key(5'd1); send_key(KEY_EQUALS);
    @(negedge clock);
    checks++; if (u_if.dbg_state !== ST_WAIT_ALU || u_if.busy !== 1'b1) begin errors++; $display("FAIL wait_alu: state=%0d busy=%b required %0d 1", u_if.dbg_state, u_if.busy, ST_WAIT_ALU); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (u_if.dbg_state !== ST_ENTRY_A || u_if.busy !== 1'b0 || u_if.key_ready !== 1'b1 || u_if.alu_num0 !== 32'd0 || u_if.disp_num !== 32'd0) begin errors++; $display("FAIL async_reset: state=%0d busy=%b ready=%b num0=%h disp=%h required 0 0 1 0 0", u_if.dbg_state, u_if.busy, u_if.key_ready, u_if.alu_num0, u_if.disp_num); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    u_if.alu_result = 32'h8;
    u_if.alu_done   = 1'b1;
    @(negedge clock);
    u_if.alu_done   = 1'b0;
    checks++; if (u_if.dbg_state !== ST_ENTRY_A || u_if.disp_num !== 32'd0) begin errors++; $display("FAIL late_done_ignored: state=%0d disp=%h required 0 0", u_if.dbg_state, u_if.disp_num); end
  endtask

  initial begin
    reset_n          = 1'b0;
    u_if.key_valid   = 1'b0;
    u_if.key_code    = 5'd0;
    u_if.alu_done    = 1'b0;
    u_if.alu_error   = 1'b0;
    u_if.alu_result  = 32'd0;
    u_if.alu_res_sgn = 1'b0;
    u_if.alu_res_dp  = 3'd0;
    test_reset();
    test_add();
    test_digit_limit();
    test_dot_sign();
    test_div_zero();
    test_chain();
    test_alu_error();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
